posit_decoder: RTL and testbench

POSIT_DECODER -- requirements
Module: posit_decoder

---
 rtl/posit_decoder.sv | 193 +++++++++++++++++++
 tb/tb_posit_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_decoder.sv
// Serial posit decoder (32-bit word, es = 3).
// A captured word is walked one bit per cycle from bit30 down to bit0, so
// every ordinary word takes the same number of cycles regardless of where
// the regime ends. Zero and NaR are recognised at capture and skip the walk.
module posit_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] posit_in,
  output logic        sign_out,
  output logic [5:0]  k_out,
  output logic [2:0]  exp_out,
  output logic [31:0] mantissa_out,
  output logic        zero,
  output logic        nar,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, SIGN, REGIME, EXP, MANT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] posit_q, posit_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  run_q, run_d;
  logic        pol_q, pol_d;
  logic [1:0]  ecnt_q, ecnt_d;
  logic [4:0]  mcnt_q, mcnt_d;
  logic        sign_q, sign_d;
  logic [5:0]  k_q, k_d;
  logic [2:0]  exp_q, exp_d;
  logic [31:0] mant_q, mant_d;
  logic        zero_q, zero_d;
  logic        nar_q, nar_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        curBit;
  logic        polBit;
  logic [4:0]  runNew;
  logic [5:0]  kNew;

  assign curBit       = posit_q[idx_q];
  assign sign_out     = sign_q;
  assign k_out        = k_q;
  assign exp_out      = exp_q;
  assign mantissa_out = mant_q;
  assign zero         = zero_q;
  assign nar          = nar_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // State and datapath registers; reset clears everything and aborts a decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      posit_q <= '0;
      idx_q   <= '0;
      run_q   <= '0;
      pol_q   <= 1'b0;
      ecnt_q  <= '0;
      mcnt_q  <= '0;
      sign_q  <= 1'b0;
      k_q     <= '0;
      exp_q   <= '0;
      mant_q  <= '0;
      zero_q  <= 1'b0;
      nar_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      posit_q <= posit_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      pol_q   <= pol_d;
      ecnt_q  <= ecnt_d;
      mcnt_q  <= mcnt_d;
      sign_q  <= sign_d;
      k_q     <= k_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      zero_q  <= zero_d;
      nar_q   <= nar_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: one bit consumed per cycle in REGIME/EXP/MANT, and the
  // cycle that consumes bit0 always leads to DONE, truncating later fields.
  always_comb begin
    state_d = state_q;
    posit_d = posit_q;
    idx_d   = idx_q;
    run_d   = run_q;
    pol_d   = pol_q;
    ecnt_d  = ecnt_q;
    mcnt_d  = mcnt_q;
    sign_d  = sign_q;
    k_d     = k_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    zero_d  = zero_q;
    nar_d   = nar_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    polBit  = pol_q;
    runNew  = run_q;
    kNew    = k_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          posit_d = posit_in;
          busy_d  = 1'b1;
          sign_d  = 1'b0;
          k_d     = '0;
          exp_d   = '0;
          mant_d  = '0;
          zero_d  = 1'b0;
          nar_d   = 1'b0;
          if (posit_in == 32'h0000_0000) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else if (posit_in == 32'h8000_0000) begin
            nar_d   = 1'b1;
            sign_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SIGN;
          end
        end
      end

      SIGN: begin
        sign_d  = posit_q[31];
        idx_d   = 5'd30;
        run_d   = '0;
        state_d = REGIME;
      end

      REGIME: begin
        // The first regime bit sets the polarity; k is refreshed every cycle
        // so a regime running all the way to bit0 still reports correctly.
        if (idx_q == 5'd30) begin
          polBit = curBit;
          pol_d  = curBit;
          runNew = 5'd1;
        end else if (curBit == pol_q) begin
          runNew = run_q + 5'd1;
        end else begin
          runNew  = run_q;
          ecnt_d  = 2'd2;
          state_d = EXP;
        end
        kNew  = polBit ? ({1'b0, runNew} - 6'd1) : (6'd0 - {1'b0, runNew});
        k_d   = kNew;
        run_d = runNew;
        idx_d = idx_q - 5'd1;
        if (idx_q == 5'd0) state_d = DONE;
      end

      EXP: begin
        exp_d[ecnt_q] = curBit;
        if (ecnt_q == 2'd0) begin
          mcnt_d  = 5'd31;
          state_d = MANT;
        end else begin
          ecnt_d = ecnt_q - 2'd1;
        end
        idx_d = idx_q - 5'd1;
        if (idx_q == 5'd0) state_d = DONE;
      end

      MANT: begin
        mant_d[mcnt_q] = curBit;
        mcnt_d = mcnt_q - 5'd1;
        idx_d  = idx_q - 5'd1;
        if (idx_q == 5'd0) state_d = DONE;
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_posit_decoder.sv
// Testbench for posit_decoder: directed vectors, control-sequence corner
// cases, and random words built by a reference posit encoder.
module tb_posit_decoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] posit_in;
  logic        sign_out;
  logic [5:0]  k_out;
  logic [2:0]  exp_out;
  logic [31:0] mantissa_out;
  logic        zero;
  logic        nar;
  logic        busy;
  logic        done;

  int cmpCount  = 0;
  int failCount = 0;

  posit_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .posit_in     (posit_in),
    .sign_out     (sign_out),
    .k_out        (k_out),
    .exp_out      (exp_out),
    .mantissa_out (mantissa_out),
    .zero         (zero),
    .nar          (nar),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] posit;
    logic        s;
    logic [5:0]  k;
    logic [2:0]  e;
    logic [31:0] m;
    logic        z;
    logic        n;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    cmpCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Starts a decode from a post-edge point with the DUT idle, scrambles
  // posit_in after capture, optionally pulses start again at edge pokeEdge,
  // and returns the edge count at which done was seen (bounded).
  task automatic applyStimulus(input logic [31:0] word, input int pokeEdge,
                               output int latency, output bit busyOk);
    start    = 1'b1;
    posit_in = word;
    @(posedge clk);
    #1;
    start    = 1'b0;
    posit_in = $urandom;
    latency  = 0;
    busyOk   = busy;
    while (latency < 50) begin
      @(posedge clk);
      #1;
      latency++;
      start = (latency == pokeEdge);
      if (start) posit_in = 32'h7FFF_FFFF;
      if (done) break;
      if (!busy) busyOk = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic s, input logic [5:0] k,
                             input logic [2:0] e, input logic [31:0] m, input logic z,
                             input logic n, input int lat, input int latency, input bit busyOk);
    checkOutput({tag, " latency"}, latency, lat);
    checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, " busyWhileActive"}, {31'd0, busyOk}, 32'd1);
    checkOutput({tag, " busyAtDone"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " sign"}, {31'd0, sign_out}, {31'd0, s});
    checkOutput({tag, " k"}, {26'd0, k_out}, {26'd0, k});
    checkOutput({tag, " exp"}, {29'd0, exp_out}, {29'd0, e});
    checkOutput({tag, " mantissa"}, mantissa_out, m);
    checkOutput({tag, " zero"}, {31'd0, zero}, {31'd0, z});
    checkOutput({tag, " nar"}, {31'd0, nar}, {31'd0, n});
  endtask

  // Reference encoder: lays out regime, exponent and fraction as a bit list,
  // keeps the first 31 bits, and reports which fields survived truncation.
  task automatic encode(input bit s, input int k, input logic [2:0] e, input logic [31:0] m,
                        output logic [31:0] word, output logic [2:0] expE, output logic [31:0] expM);
    bit bits[$];
    int regLen;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) bits.push_back(1'b1);
      bits.push_back(1'b0);
    end else begin
      for (int i = 0; i < -k; i++) bits.push_back(1'b0);
      bits.push_back(1'b1);
    end
    regLen = bits.size();
    for (int i = 2; i >= 0; i--) bits.push_back(e[i]);
    for (int i = 31; i >= 0; i--) bits.push_back(m[i]);
    word = '0;
    word[31] = s;
    for (int i = 0; i < 31; i++) word[30 - i] = bits[i];
    expE = '0;
    for (int j = 0; j < 3; j++)
      if (regLen + j < 31) expE[2 - j] = e[2 - j];
    expM = '0;
    for (int i = 0; i < 31 - regLen - 3; i++) expM[31 - i] = m[31 - i];
  endtask

  int          latency;
  bit          busyOk;
  int          doneSeen;
  int          firstDone;
  int          secondDone;
  logic [31:0] word;
  logic [2:0]  expE;
  logic [31:0] expM;
  bit          rs;
  int          rk;
  logic [2:0]  re;
  logic [31:0] rm;

  initial begin
    vecs[0] = '{32'h5700_0000, 1'b0, 6'd0,  3'd5, 32'hC000_0000, 1'b0, 1'b0, 33};
    vecs[1] = '{32'h8F00_0000, 1'b1, 6'h3D, 3'd7, 32'h0000_0000, 1'b0, 1'b0, 33};
    vecs[2] = '{32'h7FFF_FFFF, 1'b0, 6'd30, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 33};
    vecs[3] = '{32'h0000_0001, 1'b0, 6'h22, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 33};
    vecs[4] = '{32'h0000_0000, 1'b0, 6'd0,  3'd0, 32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[5] = '{32'h8000_0000, 1'b1, 6'd0,  3'd0, 32'h0000_0000, 1'b0, 1'b1, 1};
    vecs[6] = '{32'hFFFF_FFFF, 1'b1, 6'd30, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 33};
    vecs[7] = '{32'h4000_0000, 1'b0, 6'd0,  3'd0, 32'h0000_0000, 1'b0, 1'b0, 33};

    rst      = 1'b0;
    start    = 1'b0;
    posit_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOutputs",
                {sign_out, k_out, exp_out, zero, nar, busy, done} == '0 && mantissa_out == '0 ? 32'd1 : 32'd0,
                32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].posit, 0, latency, busyOk);
      checkResult($sformatf("vec%0d", i), vecs[i].s, vecs[i].k, vecs[i].e, vecs[i].m,
                  vecs[i].z, vecs[i].n, vecs[i].lat, latency, busyOk);
    end

    // Outputs must hold and done must drop after the pulse.
    @(posedge clk);
    #1;
    checkOutput("doneSingleCycle", {31'd0, done}, 32'd0);
    checkOutput("holdK", {26'd0, k_out}, 32'd0);
    checkOutput("holdSign", {31'd0, sign_out}, 32'd0);

    // A second start during an active decode is ignored.
    applyStimulus(32'h5700_0000, 10, latency, busyOk);
    checkResult("startWhileBusy", 1'b0, 6'd0, 3'd5, 32'hC000_0000, 1'b0, 1'b0, 33, latency, busyOk);

    // Reset in the middle of a decode aborts it without a done pulse.
    start    = 1'b1;
    posit_in = 32'h8F00_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("abortOutputs",
                {sign_out, k_out, exp_out, zero, nar, busy, done} == '0 && mantissa_out == '0 ? 32'd1 : 32'd0,
                32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) doneSeen++;
    end
    checkOutput("noDoneAfterAbort", doneSeen, 0);
    applyStimulus(32'h8F00_0000, 0, latency, busyOk);
    checkResult("afterAbort", 1'b1, 6'h3D, 3'd7, 32'h0, 1'b0, 1'b0, 33, latency, busyOk);

    // Held start restarts on the first idle cycle after DONE.
    @(posedge clk);
    #1;
    start      = 1'b1;
    posit_in   = 32'h5700_0000;
    firstDone  = 0;
    secondDone = 0;
    for (int e = 1; e <= 120; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (firstDone == 0) firstDone = e;
        else begin
          secondDone = e;
          break;
        end
      end
    end
    start = 1'b0;
    checkOutput("heldStartFirstDone", firstDone, 34);
    checkOutput("heldStartGap", secondDone - firstDone, 34);
    checkOutput("heldStartMant", mantissa_out, 32'hC000_0000);
    @(posedge clk);
    #1;

    // Random round trips through the reference encoder.
    for (int t = 0; t < 40; t++) begin
      rs = 1'($urandom_range(0, 1));
      rk = int'($urandom_range(0, 60)) - 30;
      re = 3'($urandom_range(0, 7));
      rm = $urandom;
      encode(rs, rk, re, rm, word, expE, expM);
      applyStimulus(word, 0, latency, busyOk);
      checkResult($sformatf("rand%0d", t), rs, 6'(rk), expE, expM, 1'b0, 1'b0, 33, latency, busyOk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
